time_param_timer: RTL and testbench

//  Parametrised successor of the traffic-controller time-parameter store.
//  - Holds NUM_PARAMS reprogrammable interval lengths (default: tBASE, tEXT, tYEL), each W bits wide.
//  - Adds an integrated countdown that times the interval selected by interval_address.
//  - Sits between the programming interface (selector/value/sync) and the FSM, which issues

---
 rtl/tlc_timing_pkg.sv | 21 ++
 rtl/time_param_timer_if.sv | 30 +++
 rtl/interval_countdown.sv | 57 +++++
 rtl/time_param_timer.sv | 78 +++++++
 tb/tb_time_param_timer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlc_timing_pkg.sv
// Shared timing constants for the traffic-light controller: entry indices, default
// interval lengths and the countdown state encoding.
package tlc_timing_pkg;

   localparam int IDX_BASE = 0;
   localparam int IDX_EXT  = 1;
   localparam int IDX_YEL  = 2;

   localparam logic [3:0] DEF_BASE = 4'd6;
   localparam logic [3:0] DEF_EXT  = 4'd3;
   localparam logic [3:0] DEF_YEL  = 4'd2;

   // Entry 0 sits in the least significant nibble.
   localparam logic [11:0] DEFAULTS_PACKED = {DEF_YEL, DEF_EXT, DEF_BASE};

   typedef enum logic {
      CD_IDLE = 1'b0,
      CD_RUN  = 1'b1
   } cd_state_e;

endpackage

// File: rtl/time_param_timer_if.sv
// Programming, read-back and countdown signals between the controller FSM / programming
// port and the time-parameter timer.
interface time_param_timer_if #(
   parameter int W     = 4,
   parameter int SEL_W = 2
);
   logic [SEL_W-1:0] selector;
   logic [W-1:0]     reprogram_value;
   logic             prg_sync_in;
   logic [SEL_W-1:0] interval_address;
   logic             start_timer;
   logic             one_hz_enable;
   logic [W-1:0]     output_value;
   logic [W-1:0]     remaining;
   logic             busy;
   logic             expired;
   logic             prg_error;

   modport master (
      output selector, reprogram_value, prg_sync_in, interval_address, start_timer,
             one_hz_enable,
      input  output_value, remaining, busy, expired, prg_error
   );

   modport slave (
      input  selector, reprogram_value, prg_sync_in, interval_address, start_timer,
             one_hz_enable,
      output output_value, remaining, busy, expired, prg_error
   );
endinterface

// File: rtl/interval_countdown.sv
// IDLE/RUN down-counter: loads on load_i, decrements on each tick_i while running and
// pulses expired_o on the edge that reaches zero.
module interval_countdown
   import tlc_timing_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_value_i,
   input  logic         tick_i,
   output logic [W-1:0] remaining_o,
   output logic         busy_o,
   output logic         expired_o
);

   cd_state_e    state_q, state_d;
   logic [W-1:0] remaining_q, remaining_d;
   logic         expired_q, expired_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CD_IDLE;
         remaining_q <= '0;
         expired_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         expired_q   <= expired_d;
      end
   end

   // A load takes priority over a coincident tick, so a restart never loses a second.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      expired_d   = 1'b0;
      if (load_i) begin
         state_d     = CD_RUN;
         remaining_d = load_value_i;
      end else if (state_q == CD_RUN && tick_i) begin
         if (remaining_q == W'(1)) begin
            state_d     = CD_IDLE;
            remaining_d = '0;
            expired_d   = 1'b1;
         end else begin
            remaining_d = remaining_q - W'(1);
         end
      end
   end

   assign remaining_o = remaining_q;
   assign busy_o      = (state_q == CD_RUN);
   assign expired_o   = expired_q;

endmodule

// File: rtl/time_param_timer.sv
// Reprogrammable interval store with edge-triggered write validation, registered
// read-back and an integrated countdown on the addressed interval.
module time_param_timer
   import tlc_timing_pkg::*;
#(
   parameter int                          W          = 4,
   parameter int                          NUM_PARAMS = 3,
   parameter int                          SEL_W      = 2,
   parameter logic [W*NUM_PARAMS-1:0]     DEFAULTS   = DEFAULTS_PACKED
) (
   input  logic              clk,
   input  logic              sys_reset,
   time_param_timer_if.slave bus
);

   localparam logic [SEL_W:0] NUM_P = NUM_PARAMS[SEL_W:0];

   logic [W-1:0] entries_q [NUM_PARAMS];
   logic         prg_hist_q;
   logic [W-1:0] output_value_q, output_value_d;
   logic         prg_error_q, prg_error_d;

   logic         wr_edge, sel_ok, wr_ok, addr_ok, start_ok;
   logic [W-1:0] rd_val;

   assign wr_edge  = bus.prg_sync_in & ~prg_hist_q;
   assign sel_ok   = ({1'b0, bus.selector} < NUM_P);
   assign wr_ok    = wr_edge && sel_ok && (bus.reprogram_value != '0);
   assign addr_ok  = ({1'b0, bus.interval_address} < NUM_P);
   assign start_ok = bus.start_timer && addr_ok;

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_PARAMS; i++) begin
         if (addr_ok && bus.interval_address == SEL_W'(i)) rd_val = entries_q[i];
      end
   end

   always_comb begin
      output_value_d = rd_val;
      prg_error_d    = (wr_edge && !wr_ok) || (bus.start_timer && !addr_ok);
   end

   // History resets high so a strobe already asserted during reset is not seen as an edge.
   always_ff @(posedge clk) begin
      if (sys_reset) begin
         for (int i = 0; i < NUM_PARAMS; i++) entries_q[i] <= DEFAULTS[i*W +: W];
         prg_hist_q     <= 1'b1;
         output_value_q <= '0;
         prg_error_q    <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_PARAMS; i++) begin
            if (wr_ok && bus.selector == SEL_W'(i)) entries_q[i] <= bus.reprogram_value;
         end
         prg_hist_q     <= bus.prg_sync_in;
         output_value_q <= output_value_d;
         prg_error_q    <= prg_error_d;
      end
   end

   // rd_val reflects the pre-write array, so a same-cycle write never reaches this load.
   interval_countdown #(
      .W (W)
   ) u_countdown (
      .clk          (clk),
      .rst          (sys_reset),
      .load_i       (start_ok),
      .load_value_i (rd_val),
      .tick_i       (bus.one_hz_enable),
      .remaining_o  (bus.remaining),
      .busy_o       (bus.busy),
      .expired_o    (bus.expired)
   );

   assign bus.output_value = output_value_q;
   assign bus.prg_error    = prg_error_q;

endmodule

// File: tb/tb_time_param_timer.sv
// Directed scenarios plus randomized traffic for time_param_timer, checked against an
// entry-array / countdown reference model kept in the bench.
module tb_time_param_timer;

   localparam int W     = 4;
   localparam int NP    = 3;
   localparam int SEL_W = 2;

   logic clk;
   logic sys_reset;
   int   n_tests;
   int   n_fail;

   time_param_timer_if #(.W(W), .SEL_W(SEL_W)) bus ();

   time_param_timer #(.W(W), .NUM_PARAMS(NP), .SEL_W(SEL_W)) dut (
      .clk       (clk),
      .sys_reset (sys_reset),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state and the outputs it predicts after the next edge.
   int m_ent [NP];
   bit m_prev;
   int m_rem;
   bit m_busy;
   int e_out, e_rem;
   bit e_busy, e_exp, e_err;

   task automatic cycle();
      int  sel, val, addr;
      bit  edge_seen;
      sel  = int'(bus.selector);
      val  = int'(bus.reprogram_value);
      addr = int'(bus.interval_address);
      if (sys_reset) begin
         m_ent[0] = 6; m_ent[1] = 3; m_ent[2] = 2;
         m_prev = 1'b1;
         m_rem = 0; m_busy = 1'b0;
         e_out = 0; e_rem = 0; e_busy = 1'b0; e_exp = 1'b0; e_err = 1'b0;
      end else begin
         edge_seen = bus.prg_sync_in && !m_prev;
         e_err = (edge_seen && (val == 0 || sel >= NP)) || (bus.start_timer && addr >= NP);
         e_out = (addr < NP) ? m_ent[addr] : 0;
         e_exp = 1'b0;
         e_rem = m_rem; e_busy = m_busy;
         if (bus.start_timer && addr < NP) begin
            e_rem = m_ent[addr]; e_busy = 1'b1;
         end else if (m_busy && bus.one_hz_enable) begin
            e_rem = m_rem - 1;
            if (e_rem == 0) begin
               e_busy = 1'b0; e_exp = 1'b1;
            end
         end
         if (edge_seen && val != 0 && sel < NP) m_ent[sel] = val;
         m_prev = bus.prg_sync_in;
         m_rem = e_rem; m_busy = e_busy;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.selector = '0; bus.reprogram_value = '0; bus.prg_sync_in = 1'b0;
      bus.interval_address = '0; bus.start_timer = 1'b0; bus.one_hz_enable = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.prg_sync_in = 1'b1; bus.selector = 2'd0; bus.reprogram_value = 4'd5;
      sys_reset = 1'b1;
      cycle(); cycle();
      n_tests++; if (bus.output_value !== 4'd0) begin n_fail++; $display("FAIL reset_out got %0d want 0", bus.output_value); end
      n_tests++; if (bus.remaining !== 4'd0) begin n_fail++; $display("FAIL reset_rem got %0d want 0", bus.remaining); end
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      n_tests++; if (bus.expired !== 1'b0) begin n_fail++; $display("FAIL reset_exp got %b want 0", bus.expired); end
      n_tests++; if (bus.prg_error !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.prg_error); end
      sys_reset = 1'b0;
      cycle();
      bus.prg_sync_in = 1'b0;
      cycle();
   endtask

   task automatic test_read_defaults();
      int want [3];
      want[0] = 6; want[1] = 3; want[2] = 2;
      for (int a = 0; a < 3; a++) begin
         bus.interval_address = SEL_W'(a);
         cycle();
         n_tests++;
         if (bus.output_value !== W'(want[a])) begin
            n_fail++; $display("FAIL default_addr%0d got %0d want %0d", a, bus.output_value, want[a]);
         end
      end
      bus.interval_address = 2'd3;
      cycle();
      n_tests++; if (bus.output_value !== 4'd0) begin n_fail++; $display("FAIL oob_read got %0d want 0", bus.output_value); end
   endtask

   task automatic test_single_write();
      bus.interval_address = 2'd1;
      bus.selector = 2'd1; bus.reprogram_value = 4'd10; bus.prg_sync_in = 1'b1;
      cycle();
      bus.reprogram_value = 4'd12;
      cycle();
      n_tests++; if (bus.output_value !== 4'd10) begin n_fail++; $display("FAIL write_latency got %0d want 10", bus.output_value); end
      cycle();
      bus.prg_sync_in = 1'b0;
      cycle();
      n_tests++; if (bus.output_value !== 4'd10) begin n_fail++; $display("FAIL held_strobe got %0d want 10", bus.output_value); end
      sys_reset = 1'b1; cycle(); sys_reset = 1'b0;
      cycle();
      n_tests++; if (bus.output_value !== 4'd3) begin n_fail++; $display("FAIL write_reset got %0d want 3", bus.output_value); end
   endtask

   task automatic test_reject();
      int want [3];
      want[0] = 6; want[1] = 3; want[2] = 2;
      bus.selector = 2'd0; bus.reprogram_value = 4'd0; bus.prg_sync_in = 1'b1;
      cycle();
      n_tests++; if (bus.prg_error !== 1'b1) begin n_fail++; $display("FAIL reject_zero got %b want 1", bus.prg_error); end
      bus.prg_sync_in = 1'b0;
      cycle();
      n_tests++; if (bus.prg_error !== 1'b0) begin n_fail++; $display("FAIL reject_pulse got %b want 0", bus.prg_error); end
      bus.selector = 2'd3; bus.reprogram_value = 4'd9; bus.prg_sync_in = 1'b1;
      cycle();
      n_tests++; if (bus.prg_error !== 1'b1) begin n_fail++; $display("FAIL reject_sel got %b want 1", bus.prg_error); end
      bus.prg_sync_in = 1'b0;
      for (int a = 0; a < 3; a++) begin
         bus.interval_address = SEL_W'(a);
         cycle();
         n_tests++;
         if (bus.output_value !== W'(want[a])) begin
            n_fail++; $display("FAIL reject_entry%0d got %0d want %0d", a, bus.output_value, want[a]);
         end
      end
      bus.interval_address = 2'd3; bus.start_timer = 1'b1;
      cycle();
      bus.start_timer = 1'b0;
      n_tests++; if (bus.prg_error !== 1'b1 || bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL reject_start got err=%b busy=%b want err=1 busy=0", bus.prg_error, bus.busy);
      end
   endtask

   task automatic test_countdown();
      bus.interval_address = 2'd2; bus.start_timer = 1'b1;
      cycle();
      bus.start_timer = 1'b0;
      n_tests++; if (bus.remaining !== 4'd2 || bus.busy !== 1'b1) begin
         n_fail++; $display("FAIL cd_load got rem=%0d busy=%b want rem=2 busy=1", bus.remaining, bus.busy);
      end
      bus.one_hz_enable = 1'b1;
      cycle();
      n_tests++; if (bus.remaining !== 4'd1 || bus.expired !== 1'b0) begin
         n_fail++; $display("FAIL cd_tick1 got rem=%0d exp=%b want rem=1 exp=0", bus.remaining, bus.expired);
      end
      cycle();
      bus.one_hz_enable = 1'b0;
      n_tests++; if (bus.remaining !== 4'd0 || bus.busy !== 1'b0 || bus.expired !== 1'b1) begin
         n_fail++; $display("FAIL cd_expire got rem=%0d busy=%b exp=%b want 0 0 1", bus.remaining, bus.busy, bus.expired);
      end
      cycle();
      n_tests++; if (bus.expired !== 1'b0) begin n_fail++; $display("FAIL cd_exp_pulse got %b want 0", bus.expired); end
   endtask

   task automatic test_restart();
      bus.interval_address = 2'd0; bus.start_timer = 1'b1;
      cycle();
      bus.start_timer = 1'b0; bus.one_hz_enable = 1'b1;
      cycle(); cycle(); cycle();
      bus.one_hz_enable = 1'b0;
      n_tests++; if (bus.remaining !== 4'd3) begin n_fail++; $display("FAIL rs_three_ticks got %0d want 3", bus.remaining); end
      bus.interval_address = 2'd1; bus.start_timer = 1'b1;
      cycle();
      bus.start_timer = 1'b0;
      n_tests++; if (bus.remaining !== 4'd3 || bus.expired !== 1'b0 || bus.busy !== 1'b1) begin
         n_fail++; $display("FAIL rs_reload got rem=%0d exp=%b busy=%b want 3 0 1", bus.remaining, bus.expired, bus.busy);
      end
      bus.one_hz_enable = 1'b1;
      cycle();
      bus.start_timer = 1'b1;
      cycle();
      bus.start_timer = 1'b0; bus.one_hz_enable = 1'b0;
      n_tests++; if (bus.remaining !== 4'd3) begin n_fail++; $display("FAIL rs_start_wins got %0d want 3", bus.remaining); end
   endtask

   task automatic test_reset_abort();
      bus.interval_address = 2'd0; bus.start_timer = 1'b1;
      cycle();
      bus.start_timer = 1'b0; bus.one_hz_enable = 1'b1;
      cycle(); cycle();
      n_tests++; if (bus.remaining !== 4'd4) begin n_fail++; $display("FAIL ab_pre got %0d want 4", bus.remaining); end
      sys_reset = 1'b1;
      cycle();
      sys_reset = 1'b0; bus.one_hz_enable = 1'b0;
      n_tests++; if (bus.remaining !== 4'd0 || bus.busy !== 1'b0 || bus.expired !== 1'b0) begin
         n_fail++; $display("FAIL ab_reset got rem=%0d busy=%b exp=%b want 0 0 0", bus.remaining, bus.busy, bus.expired);
      end
      cycle();
      n_tests++; if (bus.expired !== 1'b0) begin n_fail++; $display("FAIL ab_no_exp got %b want 0", bus.expired); end
   endtask

   task automatic test_same_cycle();
      bus.selector = 2'd2; bus.reprogram_value = 4'd9; bus.prg_sync_in = 1'b1;
      bus.interval_address = 2'd2; bus.start_timer = 1'b1;
      cycle();
      n_tests++; if (bus.remaining !== 4'd2) begin n_fail++; $display("FAIL sc_old_value got %0d want 2", bus.remaining); end
      cycle();
      bus.start_timer = 1'b0; bus.prg_sync_in = 1'b0;
      n_tests++; if (bus.remaining !== 4'd9) begin n_fail++; $display("FAIL sc_new_value got %0d want 9", bus.remaining); end
      cycle();
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         sys_reset             = ($urandom_range(0, 79) == 0);
         bus.selector          = SEL_W'($urandom_range(0, 3));
         bus.reprogram_value   = ($urandom_range(0, 5) == 0) ? 4'd0 : W'($urandom_range(1, 15));
         bus.prg_sync_in       = ($urandom_range(0, 2) == 0);
         bus.interval_address  = SEL_W'($urandom_range(0, 3));
         bus.start_timer       = ($urandom_range(0, 9) == 0);
         bus.one_hz_enable     = ($urandom_range(0, 1) == 0);
         cycle();
         n_tests++;
         if (bus.output_value !== W'(e_out) || bus.remaining !== W'(e_rem) || bus.busy !== e_busy ||
             bus.expired !== e_exp || bus.prg_error !== e_err) begin
            n_fail++;
            $display("FAIL rand_%0d got out=%0d rem=%0d busy=%b exp=%b err=%b want %0d %0d %b %b %b",
                     k, bus.output_value, bus.remaining, bus.busy, bus.expired, bus.prg_error,
                     e_out, e_rem, e_busy, e_exp, e_err);
         end
      end
      sys_reset = 1'b0;
      idle_inputs();
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      sys_reset = 1'b1;
      idle_inputs();
      m_prev = 1'b1; m_rem = 0; m_busy = 1'b0;
      m_ent[0] = 6; m_ent[1] = 3; m_ent[2] = 2;
      #1;
      test_reset();
      test_read_defaults();
      test_single_write();
      test_reject();
      test_countdown();
      test_restart();
      test_reset_abort();
      test_same_cycle();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
